round_ctrl: RTL and testbench

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/hungry_pkg.sv | 51 +++++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_round_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hungry_pkg.sv
// Shared constants for the round controller: FSM encodings, game defaults,
// active-low gfedcba seven-segment patterns and the BCD score payload.
package hungry_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned BCD_W          = 4;
  localparam int unsigned SEG_W          = 7;
  localparam int unsigned MAX_ROUNDS_DEF = 3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARM       = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY      = 3'd2;
  localparam logic [STATE_W-1:0] ST_ROUND_END = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER      = 3'd4;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Two-digit BCD score
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } score_t;

  // Increment a BCD score by one, holding at 99
  function automatic score_t bcd_inc_sat(input score_t s);
    score_t r;
    r = s;
    if (s.tens == 4'd9 && s.units == 4'd9) begin
      r = s;
    end else if (s.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = s.tens + 4'd1;
    end else begin
      r.units = s.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low gfedcba seven-segment pattern; non-BCD codes blank.
// Ports: i_bcd  - 4-bit BCD digit
//        o_seg_c - combinational active-low segment pattern
module bcd_to_seg7
  import hungry_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/round_ctrl.sv
// Game round controller: sequences IDLE/ARM/PLAY/ROUND_END/OVER, keeps a
// saturating two-digit BCD score and round counter, and drives the countdown
// timer hold plus three seven-segment displays.
// Ports: clk, reset (sync, active-high)
//        start, eat     - level inputs, rising edge acts
//        done           - countdown expired, honoured only in PLAY
//        reset_countdown- hold/reload countdown timer (low only in PLAY)
//        score_lower/score_higher/round_seg - active-low 7-seg digits
//        round_active   - high in PLAY; game_over - high in OVER
module round_ctrl
  import hungry_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             eat,
  input  logic             done,
  output logic             reset_countdown,
  output logic [SEG_W-1:0] score_lower,
  output logic [SEG_W-1:0] score_higher,
  output logic [SEG_W-1:0] round_seg,
  output logic             round_active,
  output logic             game_over
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;

  logic               r_start_q;
  logic               r_start_ok;
  logic               r_start_edge;
  logic               r_eat_q;
  logic               r_eat_edge;

  score_t             r_score;
  logic [BCD_W-1:0]   r_round;

  logic               r_reset_countdown;
  logic               r_round_active;
  logic               r_game_over;

  logic               w_score_clr;
  logic               w_score_inc;
  logic               w_round_clr;
  logic               w_round_inc;

  // Edge detect; r_start_ok blocks a start that was already high at reset
  // release from ever looking like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q    <= 1'b0;
      r_start_ok   <= 1'b0;
      r_start_edge <= 1'b0;
      r_eat_q      <= 1'b0;
      r_eat_edge   <= 1'b0;
    end else begin
      r_start_q    <= start;
      r_start_edge <= start & ~r_start_q & r_start_ok;
      if (!start) begin
        r_start_ok <= 1'b1;
      end
      r_eat_q      <= eat;
      r_eat_edge   <= eat & ~r_eat_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_score_clr = 1'b0;
    w_score_inc = 1'b0;
    w_round_clr = 1'b0;
    w_round_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_edge) begin
          w_state_nxt = ST_ARM;
          w_score_clr = 1'b1;
          w_round_clr = 1'b1;
        end
      end
      ST_ARM: begin
        w_state_nxt = ST_PLAY;
        w_round_inc = 1'b1;
      end
      ST_PLAY: begin
        // An eat coinciding with done still scores before leaving PLAY
        w_score_inc = r_eat_edge;
        if (done) begin
          w_state_nxt = (r_round < BCD_W'(MAX_ROUNDS)) ? ST_ROUND_END : ST_OVER;
        end
      end
      ST_ROUND_END: begin
        if (r_start_edge) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_OVER: begin
        // New game: round cleared here, ARM then brings it to 1
        if (r_start_edge) begin
          w_state_nxt = ST_ARM;
          w_score_clr = 1'b1;
          w_round_clr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Score and round counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_score <= '0;
      r_round <= '0;
    end else begin
      if (w_score_clr) begin
        r_score <= '0;
      end else if (w_score_inc) begin
        r_score <= bcd_inc_sat(r_score);
      end
      if (w_round_clr) begin
        r_round <= '0;
      end else if (w_round_inc) begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  // Status flags registered from next state so they track r_state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reset_countdown <= 1'b1;
      r_round_active    <= 1'b0;
      r_game_over       <= 1'b0;
    end else begin
      r_reset_countdown <= (w_state_nxt != ST_PLAY);
      r_round_active    <= (w_state_nxt == ST_PLAY);
      r_game_over       <= (w_state_nxt == ST_OVER);
    end
  end

  assign reset_countdown = r_reset_countdown;
  assign round_active    = r_round_active;
  assign game_over       = r_game_over;

  bcd_to_seg7 u_seg_units (
    .i_bcd   (r_score.units),
    .o_seg_c (score_lower)
  );

  bcd_to_seg7 u_seg_tens (
    .i_bcd   (r_score.tens),
    .o_seg_c (score_higher)
  );

  bcd_to_seg7 u_seg_round (
    .i_bcd   (r_round),
    .o_seg_c (round_seg)
  );

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus queues expected display/status
// values, a negedge monitor pops and compares them.
module tb_round_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk;
  logic       reset;
  logic       start;
  logic       eat;
  logic       done;
  logic       reset_countdown;
  logic [6:0] score_lower;
  logic [6:0] score_higher;
  logic [6:0] round_seg;
  logic       round_active;
  logic       game_over;

  typedef struct {
    string      name;
    logic [6:0] hi;
    logic [6:0] lo;
    logic [6:0] rs;
    logic       rc;
    logic       ra;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  round_ctrl #(.MAX_ROUNDS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .eat             (eat),
    .done            (done),
    .reset_countdown (reset_countdown),
    .score_lower     (score_lower),
    .score_higher    (score_higher),
    .round_seg       (round_seg),
    .round_active    (round_active),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({score_higher, score_lower, round_seg, reset_countdown, round_active, game_over} !==
          {e.hi, e.lo, e.rs, e.rc, e.ra, e.go}) begin
        errors++;
        $display("FAIL %s: got hi=%b lo=%b rs=%b rc=%b ra=%b go=%b, want hi=%b lo=%b rs=%b rc=%b ra=%b go=%b",
                 e.name, score_higher, score_lower, round_seg, reset_countdown, round_active, game_over,
                 e.hi, e.lo, e.rs, e.rc, e.ra, e.go);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [6:0] hi, input logic [6:0] lo,
                            input logic [6:0] rs, input logic rc, input logic ra, input logic go);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.rs = rs; e.rc = rc; e.ra = ra; e.go = go;
    exp_q.push_back(e);
  endtask

  // Start press; leaves the DUT in ARM
  task automatic press_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  task automatic eat_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      eat = 1'b1;
      tick(1);
      eat = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stim_done = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    eat   = 1'b0;
    done  = 1'b0;
    tick(3);
    expect_out("reset_state", S0, S0, S0, 1'b1, 1'b0, 1'b0);
    tick(1);

    // Start held through reset release must not start a game
    reset = 1'b0;
    tick(4);
    expect_out("start_held_through_reset", S0, S0, S0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(2);

    // Round 1
    press_start();
    expect_out("arm_cycle", S0, S0, S0, 1'b1, 1'b0, 1'b0);
    tick(1);
    expect_out("play_round1", S0, S0, S1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({round_seg, reset_countdown, round_active} !== {S1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL direct play_round1: rs=%b rc=%b ra=%b", round_seg, reset_countdown, round_active);
    end

    eat = 1'b1;
    tick(10);
    eat = 1'b0;
    tick(1);
    expect_out("eat_held_counts_once", S0, S1, S1, 1'b0, 1'b1, 1'b0);

    eat_pulses(11);
    expect_out("score_12", S1, S2, S1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({score_higher, score_lower} !== {S1, S2}) begin
      errors++;
      $display("FAIL direct score_12: hi=%b lo=%b", score_higher, score_lower);
    end

    pulse_done();
    expect_out("round_end_1", S1, S2, S1, 1'b1, 1'b0, 1'b0);

    eat_pulses(2);
    done = 1'b1;
    tick(2);
    done = 1'b0;
    expect_out("eat_done_ignored_round_end", S1, S2, S1, 1'b1, 1'b0, 1'b0);

    // Round 2
    press_start();
    tick(1);
    expect_out("play_round2_score_kept", S1, S2, S2, 1'b0, 1'b1, 1'b0);

    eat_pulses(29);
    expect_out("score_41", S4, S1, S2, 1'b0, 1'b1, 1'b0);

    // Eat edge lands in the same cycle as done
    eat = 1'b1;
    tick(1);
    eat  = 1'b0;
    done = 1'b1;
    tick(1);
    done = 1'b0;
    expect_out("eat_with_done", S4, S2, S2, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({score_higher, score_lower, round_active} !== {S4, S2, 1'b0}) begin
      errors++;
      $display("FAIL direct eat_with_done: hi=%b lo=%b ra=%b", score_higher, score_lower, round_active);
    end

    // Round 3
    press_start();
    tick(1);
    expect_out("play_round3", S4, S2, S3, 1'b0, 1'b1, 1'b0);

    eat_pulses(101);
    expect_out("score_saturate_99", S9, S9, S3, 1'b0, 1'b1, 1'b0);

    pulse_done();
    expect_out("game_over", S9, S9, S3, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({game_over, reset_countdown, score_higher, score_lower} !== {1'b1, 1'b1, S9, S9}) begin
      errors++;
      $display("FAIL direct game_over: go=%b rc=%b hi=%b lo=%b", game_over, reset_countdown,
               score_higher, score_lower);
    end

    eat_pulses(2);
    done = 1'b1;
    tick(2);
    done = 1'b0;
    expect_out("over_holds", S9, S9, S3, 1'b1, 1'b0, 1'b1);

    // New game from OVER
    press_start();
    expect_out("new_game_arm", S0, S0, S0, 1'b1, 1'b0, 1'b0);
    tick(1);
    expect_out("new_game_play", S0, S0, S1, 1'b0, 1'b1, 1'b0);

    eat_pulses(37);
    expect_out("score_37", S3, S7, S1, 1'b0, 1'b1, 1'b0);

    // Reset mid-PLAY aborts the round
    reset = 1'b1;
    tick(1);
    expect_out("reset_mid_play", S0, S0, S0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({score_higher, score_lower, round_seg, reset_countdown, round_active} !==
        {S0, S0, S0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL direct reset_mid_play: hi=%b lo=%b rs=%b rc=%b ra=%b", score_higher,
               score_lower, round_seg, reset_countdown, round_active);
    end
    reset = 1'b0;
    tick(2);
    expect_out("idle_after_reset", S0, S0, S0, 1'b1, 1'b0, 1'b0);

    tick(2);
    stim_done = 1'b1;
  end

  // Summary once the scoreboard has drained, with a hard time bound
  initial begin
    fork
      begin
        wait (stim_done);
        while (exp_q.size() > 0) @(negedge clk);
        @(negedge clk);
      end
      begin
        #200000;
        errors++;
        $display("FAIL timeout: stimulus did not complete, pending=%0d", exp_q.size());
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
